// File: rtl/cmd_frame_pkg.sv
// Shared constants and types for the host command deframer.
package cmd_frame_pkg;

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam int unsigned FRAME_LEN  = 7;
    // Frame minus SYNC, ADDR and CSUM.
    localparam int unsigned DATA_BYTES = FRAME_LEN - 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } cmd_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cmd_frame_parser.sv
// Deframes SYNC/ADDR/D3..D0/CSUM byte frames into single-cycle register writes;
// bad checksums and inter-byte timeouts drop the frame and are counted.
module cmd_frame_parser
    import cmd_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           i_byte,
    input  logic                 i_byte_valid,
    output logic [7:0]           o_cmd_addr,
    output logic [31:0]          o_cmd_data,
    output logic                 o_cmd_wr,
    output logic [ERR_CNT_W-1:0] o_csum_err_cnt,
    output logic [ERR_CNT_W-1:0] o_timeout_cnt,
    output logic                 o_busy
);

    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W = 2;

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    cmd_t             shadow_q, shadow_d;
    cmd_t             cmd_q, cmd_d;
    logic [7:0]       xor_q, xor_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wr_q, wr_d;
    logic             busy_q;

    logic             timeout_c;
    logic             csum_ok_c;
    logic             csum_err_c;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout_c  = (state_q != IDLE) && !i_byte_valid &&
                        (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));
    assign csum_ok_c  = (state_q == CSUM) && i_byte_valid && (i_byte == xor_q);
    assign csum_err_c = (state_q == CSUM) && i_byte_valid && (i_byte != xor_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = IDLE;
        end else if (i_byte_valid) begin
            unique case (state_q)
                IDLE: if (i_byte == SYNC_BYTE) state_d = ADDR;
                ADDR: state_d = DATA;
                DATA: if (idx_q == IDX_W'(DATA_BYTES - 1)) state_d = CSUM;
                CSUM: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath / output next values
    always_comb begin
        shadow_d = shadow_q;
        xor_d    = xor_q;
        idx_d    = idx_q;
        cmd_d    = cmd_q;
        wr_d     = 1'b0;
        gap_d    = ((state_q == IDLE) || i_byte_valid || timeout_c) ? '0 : gap_q + GAP_W'(1);
        if (i_byte_valid) begin
            unique case (state_q)
                ADDR: begin
                    shadow_d.addr = i_byte;
                    xor_d         = i_byte;
                    idx_d         = '0;
                end
                DATA: begin
                    shadow_d.data = {shadow_q.data[23:0], i_byte};
                    xor_d         = xor_q ^ i_byte;
                    idx_d         = idx_q + IDX_W'(1);
                end
                CSUM: begin
                    if (csum_ok_c) begin
                        cmd_d = shadow_q;
                        wr_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q    <= '0;
            shadow_q <= '0;
            cmd_q    <= '0;
            xor_q    <= '0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            gap_q    <= gap_d;
            shadow_q <= shadow_d;
            cmd_q    <= cmd_d;
            xor_q    <= xor_d;
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_csum_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (csum_err_c),
        .cnt   (o_csum_err_cnt)
    );

    sat_counter #(.W(ERR_CNT_W)) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (timeout_c),
        .cnt   (o_timeout_cnt)
    );

    assign o_cmd_addr = cmd_q.addr;
    assign o_cmd_data = cmd_q.data;
    assign o_cmd_wr   = wr_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser: frame-buffer reference model checked every cycle,
// plus literal expectations from the hand-worked vectors.
module tb_cmd_frame_parser;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  o_cmd_addr;
    logic [31:0] o_cmd_data;
    logic        o_cmd_wr;
    logic [7:0]  o_csum_err_cnt;
    logic [7:0]  o_timeout_cnt;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    cmd_frame_parser #(.TIMEOUT_CYCLES(TO), .ERR_CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_byte         (i_byte),
        .i_byte_valid   (i_byte_valid),
        .o_cmd_addr     (o_cmd_addr),
        .o_cmd_data     (o_cmd_data),
        .o_cmd_wr       (o_cmd_wr),
        .o_csum_err_cnt (o_csum_err_cnt),
        .o_timeout_cnt  (o_timeout_cnt),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect frame bytes in a buffer, judge the frame when 7 bytes are in.
    logic [7:0]  fbuf [7];
    int unsigned blen = 0;
    int unsigned gap = 0;
    logic        exp_wr = 1'b0;
    logic [7:0]  exp_addr = 8'h00;
    logic [31:0] exp_data = 32'h0;
    int unsigned exp_csum = 0;
    int unsigned exp_tout = 0;
    logic        exp_busy = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blen = 0; gap = 0; exp_wr = 1'b0; exp_addr = 8'h00; exp_data = 32'h0;
            exp_csum = 0; exp_tout = 0; exp_busy = 1'b0;
        end else begin
            logic [7:0] x;
            exp_wr = 1'b0;
            if (blen == 0) begin
                if (i_byte_valid && i_byte == 8'hA5) begin
                    fbuf[0] = i_byte; blen = 1; gap = 0;
                end
            end else if (i_byte_valid) begin
                fbuf[blen] = i_byte; blen++; gap = 0;
                if (blen == 7) begin
                    x = 8'h00;
                    for (int k = 1; k <= 5; k++) x = x ^ fbuf[k];
                    if (x == fbuf[6]) begin
                        exp_wr = 1'b1;
                        exp_addr = fbuf[1];
                        exp_data = {fbuf[2], fbuf[3], fbuf[4], fbuf[5]};
                    end else if (exp_csum != 255) begin
                        exp_csum++;
                    end
                    blen = 0;
                end
            end else begin
                gap++;
                if (gap == TO) begin
                    blen = 0; gap = 0;
                    if (exp_tout != 255) exp_tout++;
                end
            end
            exp_busy = (blen != 0);
        end
    end

    int cycle = 0;
    int strobes = 0;
    int strobe_cyc[$];

    always @(posedge clk) cycle++;

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("wr",   {63'd0, o_cmd_wr}, {63'd0, exp_wr});
        chk("addr", {56'd0, o_cmd_addr}, {56'd0, exp_addr});
        chk("data", {32'd0, o_cmd_data}, {32'd0, exp_data});
        chk("csum_cnt", {56'd0, o_csum_err_cnt}, 64'(exp_csum));
        chk("tout_cnt", {56'd0, o_timeout_cnt}, 64'(exp_tout));
        chk("busy", {63'd0, o_busy}, {63'd0, exp_busy});
        if (o_cmd_wr) begin
            strobes++;
            strobe_cyc.push_back(cycle);
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        i_byte = b; i_byte_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            i_byte_valid = 1'b0; i_byte = 8'h00;
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] c);
        send(8'hA5); send(a);
        send(d[31:24]); send(d[23:16]); send(d[15:8]); send(d[7:0]);
        send(c);
    endtask

    initial begin
        int s0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_addr", {56'd0, o_cmd_addr}, 64'h0);
        chk("rst_data", {32'd0, o_cmd_data}, 64'h0);
        chk("rst_busy", {63'd0, o_busy}, 64'h0);
        idle(2);

        // Basic frame
        send_frame(8'h0E, 32'hC0A8010A, 8'h6D);
        idle(3);
        chk("f1_strobes", 64'(strobes), 64'd1);
        chk("f1_addr", {56'd0, o_cmd_addr}, 64'h0E);
        chk("f1_data", {32'd0, o_cmd_data}, 64'hC0A8010A);
        chk("f1_csum", {56'd0, o_csum_err_cnt}, 64'd0);

        // Back-to-back frames
        send_frame(8'h02, 32'h00000001, 8'h03);
        send_frame(8'h0F, 32'h0A000001, 8'h04);
        idle(3);
        chk("b2b_strobes", 64'(strobes), 64'd3);
        chk("b2b_spacing", 64'(strobe_cyc[2] - strobe_cyc[1]), 64'd7);
        chk("b2b_addr", {56'd0, o_cmd_addr}, 64'h0F);
        chk("b2b_data", {32'd0, o_cmd_data}, 64'h0A000001);

        // Bad checksum
        send_frame(8'h0E, 32'hC0A8010A, 8'h6C);
        idle(3);
        chk("bad_strobes", 64'(strobes), 64'd3);
        chk("bad_csum", {56'd0, o_csum_err_cnt}, 64'd1);
        chk("bad_addr", {56'd0, o_cmd_addr}, 64'h0F);

        // Garbage prefix, 0xA5 as payload
        send(8'h11); send(8'h22);
        send_frame(8'h14, 32'h000000A5, 8'hB1);
        idle(3);
        chk("pay_addr", {56'd0, o_cmd_addr}, 64'h14);
        chk("pay_data", {32'd0, o_cmd_data}, 64'h000000A5);

        // Timeout after 16 idle cycles
        send(8'hA5); send(8'h0E);
        idle(TO);
        send_frame(8'h02, 32'h00000001, 8'h03);
        idle(3);
        chk("to_cnt", {56'd0, o_timeout_cnt}, 64'd1);
        chk("to_strobes", 64'(strobes), 64'd5);
        chk("to_data", {32'd0, o_cmd_data}, 64'h1);

        // 15 idle cycles, byte on the 16th: no timeout
        send(8'hA5); send(8'h0E);
        idle(TO - 1);
        send(8'hC0); send(8'hA8); send(8'h01); send(8'h0A); send(8'h6D);
        idle(3);
        chk("nto_cnt", {56'd0, o_timeout_cnt}, 64'd1);
        chk("nto_addr", {56'd0, o_cmd_addr}, 64'h0E);

        // Saturation
        for (int k = 0; k < 300; k++) send_frame(8'h00, 32'h0, 8'h01);
        idle(3);
        chk("sat_csum", {56'd0, o_csum_err_cnt}, 64'd255);

        // Reset mid-frame
        s0 = strobes;
        send(8'hA5); send(8'h0E); send(8'hC0);
        @(posedge clk); #1;
        i_byte_valid = 1'b0; rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        chk("mrst_addr", {56'd0, o_cmd_addr}, 64'h0);
        chk("mrst_csum", {56'd0, o_csum_err_cnt}, 64'h0);
        chk("mrst_tout", {56'd0, o_timeout_cnt}, 64'h0);
        chk("mrst_busy", {63'd0, o_busy}, 64'h0);
        send(8'hA8); send(8'h01); send(8'h0A); send(8'h6D);
        idle(3);
        chk("mrst_strobes", 64'(strobes), 64'(s0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
